mem_mc_rr: RTL and testbench

//  Multi-channel successor to the single-port memory: NUM_CH requestors share one WIDTH x DEPTH array.
//  A round-robin arbiter grants at most one request per cycle, using a per-channel valid/ready handshake.

---
 rtl/mem_mc_rr_pkg.sv | 12 +
 rtl/mem_mc_rr_arbiter.sv | 34 +++
 rtl/mem_mc_rr.sv | 133 +++++++++++++
 tb/tb_mem_mc_rr.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_mc_rr_pkg.sv
// Shared constants for the multi-channel round-robin memory: opcode encodings and index sizing.
package mem_mc_rr_pkg;

    localparam logic OP_WR = 1'b1;
    localparam logic OP_RD = 1'b0;

    // Width of a channel index; a single channel still needs one bit to carry it.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_mc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
// Latency: combinational. Backpressure: requesters not granted simply wait for a later cycle.
// Fairness comes from the caller advancing ptr past each winner.
module rr_arbiter
    import mem_mc_rr_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    int   k;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && req[k]) begin
                found   = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = PW'(k);
            end
        end
    end

endmodule

// File: rtl/mem_mc_rr.sv
// NUM_CH requestors share one WIDTH x DEPTH array through a round-robin valid/ready arbiter.
// Latency: read data and one-hot rvalid register one cycle after acceptance; one transfer per cycle.
// Backpressure: ready is the combinational grant; ungranted channels hold their request. Option: MEM_PARITY_EN.
module mem_mc_rr
    import mem_mc_rr_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NUM_CH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            valid,
    input  logic [NUM_CH-1:0]            wr_rd,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_CH*WIDTH-1:0]      wdata,
    output logic [NUM_CH-1:0]            ready,
    output logic [WIDTH-1:0]             rdata,
    output logic [NUM_CH-1:0]            rvalid,
    output logic                         err
`ifdef MEM_PARITY_EN
    ,
    output logic                         perr
`endif
);

    localparam int PW = idx_w(NUM_CH);
    localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);

    reg [WIDTH-1:0] mem [0:DEPTH-1];

    logic [PW-1:0]         ptr_q, ptr_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic [NUM_CH-1:0]     rvalid_q, rvalid_d;
    logic                  err_q, err_d;
    logic [NUM_CH-1:0]     gnt;
    logic [PW-1:0]         gnt_idx;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_wdata;
    logic                  sel_wr;
    logic                  accept;
    logic                  in_range;
    logic                  wr_en;
    logic [WIDTH-1:0]      rd_word;

    rr_arbiter #(.N(NUM_CH), .PW(PW)) u_arb (
        .req     (valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = OP_RD;
        for (int c = 0; c < NUM_CH; c++) begin
            if (gnt[c]) begin
                sel_addr  = addr[c*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = wdata[c*WIDTH +: WIDTH];
                sel_wr    = wr_rd[c];
            end
        end
    end

    assign ready    = rst ? '0 : gnt;
    assign accept   = |ready;
    assign in_range = {1'b0, sel_addr} < DEPTH_X;
    assign wr_en    = accept && (sel_wr == OP_WR) && in_range;
    assign rd_word  = in_range ? mem[sel_addr] : '0;

    always_comb begin
        ptr_d    = ptr_q;
        rdata_d  = rdata_q;
        rvalid_d = '0;
        err_d    = 1'b0;
        if (accept) begin
            ptr_d = (gnt_idx == PW'(NUM_CH - 1)) ? '0 : gnt_idx + PW'(1);
            err_d = !in_range;
            if (sel_wr == OP_RD) begin
                rvalid_d = gnt;
                rdata_d  = rd_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= '0;
            err_q    <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // Storage has no reset so testbenches can preload and dump it directly.
    always_ff @(posedge clk) begin
        if (wr_en) mem[sel_addr] <= sel_wdata;
    end

`ifdef MEM_PARITY_EN
    reg   par [0:DEPTH-1];
    logic perr_q, perr_d;

    always_comb begin
        perr_d = 1'b0;
        if (accept && (sel_wr == OP_RD) && in_range)
            perr_d = (^rd_word) != par[sel_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) perr_q <= 1'b0;
        else     perr_q <= perr_d;
    end

    always_ff @(posedge clk) begin
        if (wr_en) par[sel_addr] <= ^sel_wdata;
    end

    assign perr = perr_q;
`endif

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;

endmodule

// File: tb/tb_mem_mc_rr.sv
// Directed and randomized bench for mem_mc_rr against an array/queue-level reference model.
module tb_mem_mc_rr;

    localparam int W  = 16;
    localparam int D  = 48;
    localparam int AW = 6;
    localparam int NC = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NC-1:0]    valid, wr_rd, ready, rvalid;
    logic [NC*AW-1:0] addr;
    logic [NC*W-1:0]  wdata;
    logic [W-1:0]     rdata;
    logic             err;
`ifdef MEM_PARITY_EN
    logic             perr;
`endif

    mem_mc_rr #(.WIDTH(W), .DEPTH(D), .NUM_CH(NC)) dut (
        .clk    (clk),
        .rst    (rst),
        .valid  (valid),
        .wr_rd  (wr_rd),
        .addr   (addr),
        .wdata  (wdata),
        .ready  (ready),
        .rdata  (rdata),
        .rvalid (rvalid),
        .err    (err)
`ifdef MEM_PARITY_EN
        ,
        .perr   (perr)
`endif
    );

    always #5 clk = ~clk;

    int            tests = 0;
    int            fails = 0;
    logic [W-1:0]  mdl [0:D-1];
    int            mptr = 0;
    logic [W-1:0]  m_rdata = '0;
    logic [NC-1:0] m_gnt;
    int            bad_addr = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NC*AW-1:0] a1(input int c, input int av);
        logic [NC*AW-1:0] r;
        r = '0;
        r[c*AW +: AW] = AW'(av);
        return r;
    endfunction

    function automatic logic [NC*W-1:0] d1(input int c, input logic [W-1:0] dv);
        logic [NC*W-1:0] r;
        r = '0;
        r[c*W +: W] = dv;
        return r;
    endfunction

    // One clock cycle: drive requests, predict the grant and the registered results, compare both.
    task automatic cyc(input logic [NC-1:0] v, input logic [NC-1:0] w,
                       input logic [NC*AW-1:0] a, input logic [NC*W-1:0] d);
        logic [NC-1:0] exp_rv;
        logic          exp_err;
        logic          exp_perr;
        int            g;
        int            ga;
        valid = v;
        wr_rd = w;
        addr  = a;
        wdata = d;
        #3;
        m_gnt = '0;
        g     = -1;
        if (!rst)
            for (int i = 0; i < NC; i++)
                if (g < 0 && v[(mptr + i) % NC]) g = (mptr + i) % NC;
        if (g >= 0) m_gnt[g] = 1'b1;
        check("ready", 64'(ready), 64'(m_gnt));
        exp_rv   = '0;
        exp_err  = 1'b0;
        exp_perr = 1'b0;
        if (rst) begin
            mptr    = 0;
            m_rdata = '0;
        end else if (g >= 0) begin
            mptr    = (g + 1) % NC;
            ga      = int'(a[g*AW +: AW]);
            exp_err = (ga >= D);
            if (w[g]) begin
                if (ga < D) mdl[ga] = d[g*W +: W];
            end else begin
                exp_rv[g] = 1'b1;
                m_rdata   = (ga < D) ? mdl[ga] : '0;
                exp_perr  = (ga == bad_addr);
            end
        end
        @(posedge clk);
        #1;
        check("rvalid", 64'(rvalid), 64'(exp_rv));
        check("rdata", 64'(rdata), 64'(m_rdata));
        check("err", 64'(err), 64'(exp_err));
`ifdef MEM_PARITY_EN
        check("perr", 64'(perr), 64'(exp_perr));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NC-1:0]    pv, pw;
        logic [NC*AW-1:0] pa;
        logic [NC*W-1:0]  pd;
        logic [W-1:0]     val;
        logic [NC*AW-1:0] all_a;

        rst   = 1'b1;
        valid = '0;
        wr_rd = '0;
        addr  = '0;
        wdata = '0;
        @(posedge clk);
        #1;
        cyc(4'b1111, 4'b0000, '0, '0);
        cyc(4'b0000, 4'b0000, '0, '0);
        rst = 1'b0;

        // Backdoor preload, then front-door read of every word on channel 0.
        for (int i = 0; i < D; i++) begin
            val = W'($urandom);
            dut.mem[i] <= val;
`ifdef MEM_PARITY_EN
            dut.par[i] <= ^val;
`endif
            mdl[i] = val;
        end
        #1;
        for (int i = 0; i < D; i++) cyc(4'b0001, 4'b0000, a1(0, i), '0);

        // Round robin from ptr=0 with every channel requesting.
        rst = 1'b1;
        cyc(4'b0000, 4'b0000, '0, '0);
        rst   = 1'b0;
        all_a = '0;
        for (int c = 0; c < NC; c++) all_a[c*AW +: AW] = AW'(10 + c);
        for (int n = 0; n < 5; n++) cyc(4'b1111, 4'b0000, all_a, '0);

        // Read-after-write on consecutive cycles from different channels.
        cyc(4'b0100, 4'b0100, a1(2, 5), d1(2, 16'hBEEF));
        cyc(4'b0010, 4'b0000, a1(1, 5), '0);
        check("raw_rdata", 64'(rdata), 64'(16'hBEEF));

        // Out-of-range read and write, then read the words a truncated address would alias.
        cyc(4'b1000, 4'b0000, a1(3, 50), '0);
        cyc(4'b1000, 4'b1000, a1(3, 50), d1(3, 16'h1234));
        cyc(4'b1000, 4'b1000, a1(3, 63), d1(3, 16'h5678));
        cyc(4'b0001, 4'b0000, a1(0, 2), '0);
        cyc(4'b0001, 4'b0000, a1(0, 18), '0);
        cyc(4'b0001, 4'b0000, a1(0, 47), '0);

        // Reset in the cycle after a read is accepted; ptr must restart at channel 0.
        cyc(4'b0001, 4'b0000, a1(0, 3), '0);
        rst = 1'b1;
        cyc(4'b0000, 4'b0000, '0, '0);
        rst = 1'b0;
        cyc(4'b1111, 4'b0000, all_a, '0);
        cyc(4'b0001, 4'b0000, a1(0, 3), '0);

`ifdef MEM_PARITY_EN
        dut.mem[7] <= mdl[7] ^ 16'h0008;
        #1;
        mdl[7]   = mdl[7] ^ 16'h0008;
        bad_addr = 7;
        cyc(4'b0001, 4'b0000, a1(0, 7), '0);
        cyc(4'b0001, 4'b0001, a1(0, 7), d1(0, 16'h00F0));
        bad_addr = -1;
        cyc(4'b0001, 4'b0000, a1(0, 7), '0);
`endif

        // Randomized traffic: requests held until granted, occasional withdrawals and resets.
        pv = '0;
        pw = '0;
        pa = '0;
        pd = '0;
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NC; c++) begin
                if (pv[c] && $urandom_range(15) == 0) begin
                    pv[c] = 1'b0;
                end else if (!pv[c] && $urandom_range(1) == 1) begin
                    pv[c]           = 1'b1;
                    pw[c]           = 1'($urandom_range(1));
                    pa[c*AW +: AW]  = AW'($urandom_range(55));
                    pd[c*W +: W]    = W'($urandom);
                end
            end
            rst = ($urandom_range(99) == 0);
            cyc(pv, pw, pa, pd);
            pv  = pv & ~m_gnt;
            rst = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
